// File: rtl/data_mem_lane.sv
// Byte-addressable data memory for the MEM stage, with LSB-aligned store/load lanes
// and a valid/ready word-dump port that the debug unit uses to stream the contents.
module data_mem_lane #(
    parameter int DATA_SIZE = 32,
    parameter int TYPE = 3,
    parameter int DEPTH = 32,
    parameter int IDX_SIZE = 5,
    parameter logic [TYPE-1:0] BYTE_WORD = 3'd0,
    parameter logic [TYPE-1:0] HALF_WORD = 3'd1,
    parameter logic [TYPE-1:0] COMPLETE_WORD = 3'd2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_read,
    input  logic                 i_write,
    input  logic [TYPE-1:0]      i_word_size,
    input  logic [DATA_SIZE-1:0] i_addr,
    input  logic [DATA_SIZE-1:0] i_write_data,
    output logic [DATA_SIZE-1:0] o_read_data,
    output logic                 o_misaligned,
    output logic                 o_busy,
    input  logic                 i_dump_start,
    input  logic                 i_dump_ready,
    output logic                 o_dump_valid,
    output logic [DATA_SIZE-1:0] o_dump_data,
    output logic                 o_dump_done,
    output logic [1:0]           o_dbg_state
);

    localparam int LANES = DATA_SIZE / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DUMP = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Dump handshake: a word transfers on any rising edge where o_dump_valid and
    // i_dump_ready are both high; o_dump_data holds steady until that happens.

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [1:0]           state_q, state_d;
    logic [IDX_SIZE-1:0]  idx_q, idx_d;

    logic [IDX_SIZE-1:0]  word_idx;
    logic [1:0]           lane;
    logic                 bad;
    logic                 wr_en;
    logic [LANES-1:0]     wr_be;
    logic [DATA_SIZE-1:0] wr_data;
    logic [DATA_SIZE-1:0] rd_word;
    logic                 unused_addr;

    assign word_idx    = i_addr[IDX_SIZE+1:2];
    assign lane        = i_addr[1:0];
    assign unused_addr = ^i_addr[DATA_SIZE-1:IDX_SIZE+2];
    assign rd_word     = mem_q[word_idx];

    always_comb begin
        bad = 1'b1;
        case (i_word_size)
            BYTE_WORD:     bad = 1'b0;
            HALF_WORD:     bad = i_addr[0];
            COMPLETE_WORD: bad = |i_addr[1:0];
            default:       bad = 1'b1;
        endcase
    end

    assign o_misaligned = (i_read | i_write) & bad;
    assign o_busy       = (state_q != S_IDLE);
    assign wr_en        = i_write & ~bad & ~o_busy;

    // Store data is replicated across lanes so the byte enables alone select placement.
    always_comb begin
        wr_be   = '0;
        wr_data = i_write_data;
        case (i_word_size)
            BYTE_WORD: begin
                wr_be   = LANES'(1) << lane;
                wr_data = {LANES{i_write_data[7:0]}};
            end
            HALF_WORD: begin
                wr_be   = LANES'(3) << {lane[1], 1'b0};
                wr_data = {(LANES/2){i_write_data[15:0]}};
            end
            COMPLETE_WORD: begin
                wr_be   = '1;
                wr_data = i_write_data;
            end
            default: begin
                wr_be   = '0;
                wr_data = i_write_data;
            end
        endcase
    end

    always_comb begin
        o_read_data = '0;
        if (i_read && !bad) begin
            case (i_word_size)
                BYTE_WORD:     o_read_data = DATA_SIZE'(rd_word[{lane, 3'b000} +: 8]);
                HALF_WORD:     o_read_data = DATA_SIZE'(rd_word[{lane[1], 4'b0000} +: 16]);
                COMPLETE_WORD: o_read_data = rd_word;
                default:       o_read_data = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_be[l]) begin
                    mem_q[word_idx][l*8 +: 8] <= wr_data[l*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (i_dump_start) begin
                    state_d = S_DUMP;
                    idx_d   = '0;
                end
            end
            S_DUMP: begin
                if (i_dump_ready) begin
                    if (idx_q == IDX_SIZE'(DEPTH - 1)) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign o_dump_valid = (state_q == S_DUMP);
    assign o_dump_data  = o_dump_valid ? mem_q[idx_q] : '0;
    assign o_dump_done  = (state_q == S_DONE);
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_lane.sv
// Directed self-checking bench for data_mem_lane: lane placement, alignment, wrap,
// and the valid/ready dump stream including back-pressure and reset mid-dump.
module tb_data_mem_lane;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DUMP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_read;
    logic        i_write;
    logic [2:0]  i_word_size;
    logic [31:0] i_addr;
    logic [31:0] i_write_data;
    logic [31:0] o_read_data;
    logic        o_misaligned;
    logic        o_busy;
    logic        i_dump_start;
    logic        i_dump_ready;
    logic        o_dump_valid;
    logic [31:0] o_dump_data;
    logic        o_dump_done;
    logic [1:0]  o_dbg_state;

    int n_vec;
    int n_bad;
    logic [31:0] exp_q[$];

    data_mem_lane dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_word_size  (i_word_size),
        .i_addr       (i_addr),
        .i_write_data (i_write_data),
        .o_read_data  (o_read_data),
        .o_misaligned (o_misaligned),
        .o_busy       (o_busy),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_data  (o_dump_data),
        .o_dump_done  (o_dump_done),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Dump fill pattern: word i = 0x1000_0000 + i * 0x0001_0101.
    function automatic logic [31:0] pat(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_store(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        @(negedge i_clk);
        i_write      = 1'b1;
        i_addr       = a;
        i_word_size  = sz;
        i_write_data = d;
        @(posedge i_clk);
        #1;
        i_write = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] sz,
                           output logic [31:0] d, output logic m);
        @(negedge i_clk);
        i_read      = 1'b1;
        i_addr      = a;
        i_word_size = sz;
        #1;
        d = o_read_data;
        m = o_misaligned;
        i_read = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        logic m;
        i_reset_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        n_vec++;
        if (o_busy !== 1'b0 || o_dump_valid !== 1'b0 || o_dump_done !== 1'b0 ||
            o_read_data !== 32'h0 || o_misaligned !== 1'b0 || o_dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b valid=%b done=%b rd=%h mis=%b st=%0d, want all zero",
                     o_busy, o_dump_valid, o_dump_done, o_read_data, o_misaligned, o_dbg_state);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        do_load(32'h0000_0014, SZ_W, d, m);
        n_vec++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mem: got %h want 00000000", d);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] d;
        logic m;
        do_store(32'h08, SZ_W, 32'hDEAD_BEEF);
        do_load(32'h09, SZ_B, d, m);
        n_vec++;
        if (d !== 32'h0000_00BE || m !== 1'b0) begin
            n_bad++;
            $display("FAIL load_byte_09: got %h mis=%b want 000000be mis=0", d, m);
        end
        do_load(32'h0A, SZ_H, d, m);
        n_vec++;
        if (d !== 32'h0000_DEAD) begin
            n_bad++;
            $display("FAIL load_half_0a: got %h want 0000dead", d);
        end
        do_load(32'h08, SZ_H, d, m);
        n_vec++;
        if (d !== 32'h0000_BEEF) begin
            n_bad++;
            $display("FAIL load_half_08: got %h want 0000beef", d);
        end
        do_load(32'h0B, SZ_B, d, m);
        n_vec++;
        if (d !== 32'h0000_00DE) begin
            n_bad++;
            $display("FAIL load_byte_0b: got %h want 000000de", d);
        end
    endtask

    task automatic test_merge();
        logic [31:0] d;
        logic m;
        do_store(32'h0C, SZ_W, 32'h1122_3344);
        do_store(32'h0D, SZ_B, 32'hFFFF_FF5A);
        do_load(32'h0C, SZ_W, d, m);
        n_vec++;
        if (d !== 32'h1122_5A44) begin
            n_bad++;
            $display("FAIL byte_merge: got %h want 11225a44", d);
        end
        do_store(32'h0E, SZ_H, 32'h9999_ABCD);
        do_load(32'h0C, SZ_W, d, m);
        n_vec++;
        if (d !== 32'hABCD_5A44) begin
            n_bad++;
            $display("FAIL half_merge: got %h want abcd5a44", d);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] d;
        logic m;
        do_load(32'h03, SZ_H, d, m);
        n_vec++;
        if (m !== 1'b1 || d !== 32'h0) begin
            n_bad++;
            $display("FAIL mis_half_03: mis=%b rd=%h want mis=1 rd=00000000", m, d);
        end
        do_load(32'h08, 3'd7, d, m);
        n_vec++;
        if (m !== 1'b1 || d !== 32'h0) begin
            n_bad++;
            $display("FAIL mis_bad_size: mis=%b rd=%h want mis=1 rd=00000000", m, d);
        end
        @(negedge i_clk);
        i_write      = 1'b1;
        i_addr       = 32'h06;
        i_word_size  = SZ_W;
        i_write_data = 32'hFFFF_FFFF;
        #1;
        n_vec++;
        if (o_misaligned !== 1'b1) begin
            n_bad++;
            $display("FAIL mis_word_06: mis=%b want 1", o_misaligned);
        end
        @(posedge i_clk);
        #1;
        i_write = 1'b0;
        do_load(32'h04, SZ_W, d, m);
        n_vec++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL mis_no_store_04: got %h want 00000000", d);
        end
        do_load(32'h08, SZ_W, d, m);
        n_vec++;
        if (d !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL mis_no_store_08: got %h want deadbeef", d);
        end
        @(negedge i_clk);
        i_addr      = 32'h03;
        i_word_size = SZ_H;
        #1;
        n_vec++;
        if (o_misaligned !== 1'b0) begin
            n_bad++;
            $display("FAIL mis_no_access: mis=%b want 0", o_misaligned);
        end
    endtask

    task automatic test_read_write_same();
        @(negedge i_clk);
        i_read       = 1'b1;
        i_write      = 1'b1;
        i_addr       = 32'h10;
        i_word_size  = SZ_W;
        i_write_data = 32'hCAFE_F00D;
        #1;
        n_vec++;
        if (o_read_data !== 32'h0) begin
            n_bad++;
            $display("FAIL rw_pre_edge: got %h want 00000000", o_read_data);
        end
        @(posedge i_clk);
        #1;
        i_write = 1'b0;
        #1;
        n_vec++;
        if (o_read_data !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL rw_post_edge: got %h want cafef00d", o_read_data);
        end
        i_read = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic m;
        do_store(32'h80, SZ_W, 32'h0BAD_C0DE);
        do_load(32'h00, SZ_W, d, m);
        n_vec++;
        if (d !== 32'h0BAD_C0DE) begin
            n_bad++;
            $display("FAIL wrap_0x80: got %h want 0badc0de", d);
        end
    endtask

    task automatic test_dump();
        logic [31:0] d;
        logic m;
        int got;
        int cyc;
        bit rdy;
        for (int i = 0; i < 32; i++) begin
            do_store(32'(i * 4), SZ_W, pat(i));
            exp_q.push_back(pat(i));
        end
        @(negedge i_clk);
        i_dump_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_dump_start = 1'b0;
        n_vec++;
        if (o_busy !== 1'b1 || o_dbg_state !== ST_DUMP) begin
            n_bad++;
            $display("FAIL dump_enter: busy=%b st=%0d want busy=1 st=1", o_busy, o_dbg_state);
        end
        got = 0;
        cyc = 0;
        rdy = 1'b0;
        while (got < 32 && cyc < 400) begin
            @(negedge i_clk);
            rdy          = ~rdy;
            i_dump_ready = rdy;
            // A store and a restart request mid-dump must both be ignored.
            i_write      = (cyc == 5);
            i_dump_start = (cyc == 7);
            i_addr       = 32'h00;
            i_word_size  = SZ_W;
            i_write_data = 32'hFFFF_FFFF;
            #1;
            n_vec++;
            if (o_dump_valid !== 1'b1 || o_dump_data !== exp_q[0] || o_dump_done !== 1'b0) begin
                n_bad++;
                $display("FAIL dump_word_%0d: valid=%b data=%h done=%b want valid=1 data=%h done=0",
                         got, o_dump_valid, o_dump_data, o_dump_done, exp_q[0]);
            end
            @(posedge i_clk);
            if (rdy) begin
                void'(exp_q.pop_front());
                got++;
            end
            cyc++;
        end
        #1;
        i_dump_ready = 1'b0;
        i_write      = 1'b0;
        i_dump_start = 1'b0;
        n_vec++;
        if (got != 32) begin
            n_bad++;
            $display("FAIL dump_timeout: accepted %0d words want 32", got);
        end
        n_vec++;
        if (o_dump_done !== 1'b1 || o_dump_valid !== 1'b0 || o_busy !== 1'b1 || o_dbg_state !== ST_DONE) begin
            n_bad++;
            $display("FAIL dump_done: done=%b valid=%b busy=%b st=%0d want 1 0 1 2",
                     o_dump_done, o_dump_valid, o_busy, o_dbg_state);
        end
        @(posedge i_clk);
        #1;
        n_vec++;
        if (o_dump_done !== 1'b0 || o_busy !== 1'b0 || o_dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL dump_done_pulse: done=%b busy=%b st=%0d want 0 0 0",
                     o_dump_done, o_busy, o_dbg_state);
        end
        do_load(32'h00, SZ_W, d, m);
        n_vec++;
        if (d !== pat(0)) begin
            n_bad++;
            $display("FAIL dump_store_blocked: got %h want %h", d, pat(0));
        end
    endtask

    task automatic test_reset_mid_dump();
        logic [31:0] d;
        logic m;
        @(negedge i_clk);
        i_dump_start = 1'b1;
        i_dump_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_dump_start = 1'b0;
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        n_vec++;
        if (o_dump_data !== 32'h100A_0A0A) begin
            n_bad++;
            $display("FAIL mid_dump_idx10: got %h want 100a0a0a", o_dump_data);
        end
        i_reset_n = 1'b0;
        #1;
        n_vec++;
        if (o_dump_valid !== 1'b0 || o_busy !== 1'b0 || o_dump_done !== 1'b0 ||
            o_dump_data !== 32'h0 || o_dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL mid_dump_reset: valid=%b busy=%b done=%b data=%h st=%0d want all zero",
                     o_dump_valid, o_busy, o_dump_done, o_dump_data, o_dbg_state);
        end
        i_dump_ready = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        n_vec++;
        if (o_dump_done !== 1'b0 || o_dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL mid_dump_no_done: done=%b st=%0d want 0 0", o_dump_done, o_dbg_state);
        end
        do_load(32'h28, SZ_W, d, m);
        n_vec++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_dump_mem_clear: got %h want 00000000", d);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_vec        = 0;
        n_bad        = 0;
        i_reset_n    = 1'b0;
        i_read       = 1'b0;
        i_write      = 1'b0;
        i_word_size  = SZ_B;
        i_addr       = '0;
        i_write_data = '0;
        i_dump_start = 1'b0;
        i_dump_ready = 1'b0;
        test_reset();
        test_byte_half();
        test_merge();
        test_misaligned();
        test_read_write_same();
        test_wrap();
        test_dump();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
